uart_alu_frame_engine: RTL and testbench
========================================

Name: uart_alu_frame_engine

Overview:
- Byte-level command engine between the UART Receiver and Transmitter.
- Parses request frames (start byte, opcode, operand A, operand B, end byte), executes ADD/SUB/MUL/DIV on OPW-bit operands, and returns a response frame (status plus 2*OPW-bit result).
- Successor of the fixed 8-bit calculator path: width-generic, multi-byte operands, iterative divider, error status, inter-byte timeout.

Parameters:
- OPW, 8, operand width in bits; multiple of 8, range 8..32; NB = OPW/8 bytes per operand.
- REQ_SOF, 8'h0C, request start byte.
- REQ_EOF, 8'hFF, request end byte.
- RSP_SOF, 8'h20, response start byte.
- RSP_EOF, 8'h0A, response end byte.
- TIMEOUT_CYC, 100000, max clk cycles between request bytes; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- rx_data  in  8  byte from Receiver
- rx_valid  in  1  one-cycle strobe, rx_data valid
- tx_data  out  8  byte to Transmitter; held stable from tx_start until tx_done
- tx_start  out  1  one-cycle pulse, start sending tx_data
- tx_done  in  1  one-cycle pulse, Transmitter finished the byte
- busy  out  1  high from accepted EOF until last response byte's tx_done
- frame_err  out  1  one-cycle pulse on timeout or bad EOF
- frame_cnt  out  16  responses completed, wraps at 16'hFFFF
- drop_cnt  out  8  bytes dropped while busy, saturates at 8'hFF

Behaviour:
- Reset (asynchronous on reset low; all outputs and counters 0, state IDLE): tx_start=0, tx_data=0, busy=0, frame_err=0, frame_cnt=0, drop_cnt=0, divider cleared. Reset mid-frame or mid-response aborts immediately; no partial byte is re-sent after release.
- States: IDLE, OPC, OPA, OPB, END, EXEC, RSP, WAIT.
- IDLE: rx_valid && rx_data==REQ_SOF -> OPC. Other bytes are ignored silently.
- OPC: next byte is the opcode -> OPA.
- OPA: NB bytes, MSB first, shifted into A -> OPB.
- OPB: NB bytes, MSB first, shifted into B -> END.
- END: if byte==REQ_EOF -> EXEC; otherwise frame_err pulse -> IDLE and no response. A byte equal to REQ_SOF inside OPC..OPB is data, not a resync.
- Timeout: an idle-byte counter runs in OPC..END and resets on each rx_valid. Reaching TIMEOUT_CYC gives a frame_err pulse -> IDLE.
- Opcodes: 1 ADD, 2 SUB, 3 MUL, 4 DIV. Any other opcode gives status 8'h01 and result 0.
- Result width is RW = 2*OPW.
  - ADD: zero-extended A+B (carry in bit OPW).
  - SUB: A-B, sign-extended to RW.
  - MUL: full unsigned product.
  - DIV: quotient in [RW-1:OPW], remainder in [OPW-1:0]. B==0 gives status 8'h02, result 0, and the divider does not run.
  - Status 8'h00 on success.
- EXEC latency, EOF accept to first tx_start:
  - ADD/SUB/MUL and errors: 2 cycles.
  - DIV: OPW+2 cycles (restoring divider, one bit per cycle).
- RSP/WAIT: sends RSP_SOF, status, NB*2 result bytes MSB first, RSP_EOF.
  - One tx_start pulse per byte; the next byte is issued the cycle after tx_done.
  - tx_done outside WAIT is ignored.
  - After the last tx_done: frame_cnt+1, busy=0, -> IDLE.
- While busy, any rx_valid is discarded and increments drop_cnt (saturating).
- rx_valid and tx_done in the same cycle are both handled independently.

Optional Feature:
- Macro FRAME_CHECKSUM_EN.
- Defined:
  - The request carries an XOR checksum byte between B and EOF, covering opcode, A and B. A mismatch gives status 8'h04, result 0, and a response is still sent.
  - The response carries an XOR checksum byte before RSP_EOF, covering status and result bytes.
- Undefined: no checksum byte in either direction; the END state directly follows OPB.

Test Plan:
- OPW=8: rx 0C,01,05,03,FF -> tx 20,00,00,08,0A; frame_cnt=1.
- OPW=16: rx 0C,04,00,64,00,07,FF -> tx 20,00,00,0E,00,02,0A (quotient 14, remainder 2); first tx_start exactly 18 cycles after EOF strobe.
- OPW=8 SUB 03-05: rx 0C,02,03,05,FF -> tx 20,00,FF,FE,0A. DIV by zero -> status 02, result 00,00.
- Bad EOF (0C,01,01,01,11) -> frame_err pulse, no tx_start. TIMEOUT_CYC=50 with an 60-cycle gap after opcode -> frame_err pulse, next 0C starts a fresh frame.
- 3 bytes injected during response -> drop_cnt=3, response bytes unchanged. Reset low during 3rd response byte -> all outputs 0, IDLE.
- FRAME_CHECKSUM_EN, OPW=8: rx 0C,01,05,03,07,FF -> tx 20,00,00,08,08,0A. Wrong checksum 00 -> tx 20,04,00,00,04,0A.

Source files
------------

// File: rtl/uart_alu_frame_engine.sv
// Request/response frame engine between UART RX and TX: parses opcode and operands, runs ADD/SUB/MUL/DIV, returns status + result.
// Optional macro FRAME_CHECKSUM_EN adds an XOR checksum byte to both request and response frames.
module uart_alu_frame_engine #(
  parameter int unsigned OPW         = 8,
  parameter logic [7:0]  REQ_SOF     = 8'h0C,
  parameter logic [7:0]  REQ_EOF     = 8'hFF,
  parameter logic [7:0]  RSP_SOF     = 8'h20,
  parameter logic [7:0]  RSP_EOF     = 8'h0A,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_done,
  output logic        busy,
  output logic        frame_err,
  output logic [15:0] frame_cnt,
  output logic [7:0]  drop_cnt
);
  localparam int unsigned NB  = OPW / 8;
  localparam int unsigned RW  = 2 * OPW;
  localparam int unsigned TW  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int unsigned DCW = $clog2(OPW + 1);
`ifdef FRAME_CHECKSUM_EN
  localparam int unsigned NRSP = 2 * NB + 4;
`else
  localparam int unsigned NRSP = 2 * NB + 3;
`endif

  localparam logic [7:0] OP_ADD = 8'd1;
  localparam logic [7:0] OP_SUB = 8'd2;
  localparam logic [7:0] OP_MUL = 8'd3;
  localparam logic [7:0] OP_DIV = 8'd4;

  typedef enum logic [3:0] {
    S_IDLE, S_OPC, S_OPA, S_OPB, S_CHK, S_END, S_EXEC, S_RSP, S_WAIT
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       opc;
  logic [OPW-1:0]   a, b;
  logic [2:0]       bcnt;
  logic [TW-1:0]    idle_cnt;
  logic [OPW-1:0]   div_rem, div_quo;
  logic [DCW-1:0]   div_cnt;
  logic [7:0]       status;
  logic [RW-1:0]    rsp_sr;
  logic [3:0]       idx;
  logic             ck_ok;
`ifdef FRAME_CHECKSUM_EN
  logic [7:0]       rx_ck, rsp_ck, res_ck_c;
`endif

  logic             in_frame_c, timeout_c, last_byte_c, last_rsp_c;
  logic             div_run_c, div_busy_c, div_ge_c;
  logic [OPW:0]     div_sh_c, div_sub_c, sub_c;
  logic [7:0]       status_c, rsp_byte_c;
  logic [RW-1:0]    res_c;
  logic             issue_c, err_c, eof_ok_c, done_c;

  assign in_frame_c  = (state_q == S_OPC) || (state_q == S_OPA) || (state_q == S_OPB) ||
                       (state_q == S_CHK) || (state_q == S_END);
  assign timeout_c   = (TIMEOUT_CYC != 0) && in_frame_c && !rx_valid &&
                       (idle_cnt == TW'(TIMEOUT_CYC - 1));
  assign last_byte_c = (bcnt == 3'(NB - 1));
  assign last_rsp_c  = (idx == 4'(NRSP - 1));
  assign div_run_c   = (opc == OP_DIV) && (b != '0) && ck_ok;
  assign div_busy_c  = div_run_c && (div_cnt != DCW'(OPW));
  // Restoring divider step: shift one dividend bit into the partial remainder
  assign div_sh_c    = {div_rem, div_quo[OPW-1]};
  assign div_sub_c   = div_sh_c - {1'b0, b};
  assign div_ge_c    = !div_sub_c[OPW];
  assign sub_c       = {1'b0, a} - {1'b0, b};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (rx_valid && rx_data == REQ_SOF) state_d = S_OPC;
      S_OPC:  if (rx_valid) state_d = S_OPA;
      S_OPA:  if (rx_valid && last_byte_c) state_d = S_OPB;
`ifdef FRAME_CHECKSUM_EN
      S_OPB:  if (rx_valid && last_byte_c) state_d = S_CHK;
      S_CHK:  if (rx_valid) state_d = S_END;
`else
      S_OPB:  if (rx_valid && last_byte_c) state_d = S_END;
`endif
      S_END:  if (rx_valid) state_d = (rx_data == REQ_EOF) ? S_EXEC : S_IDLE;
      S_EXEC: if (!div_busy_c) state_d = S_RSP;
      S_RSP:  state_d = S_WAIT;
      S_WAIT: if (tx_done) state_d = last_rsp_c ? S_IDLE : S_RSP;
      default: state_d = S_IDLE;
    endcase
    if (timeout_c) state_d = S_IDLE;
  end

  always_comb begin
    issue_c  = 1'b0;
    err_c    = 1'b0;
    eof_ok_c = 1'b0;
    done_c   = 1'b0;
    case (state_q)
      S_END: begin
        if (rx_valid && rx_data == REQ_EOF) eof_ok_c = 1'b1;
        if (rx_valid && rx_data != REQ_EOF) err_c    = 1'b1;
      end
      S_RSP:  issue_c = 1'b1;
      S_WAIT: if (tx_done && last_rsp_c) done_c = 1'b1;
      default: ;
    endcase
    if (timeout_c) err_c = 1'b1;
  end

  // Status/result selection; a checksum error overrides every opcode
  always_comb begin
    status_c = 8'h00;
    res_c    = '0;
    if (!ck_ok) status_c = 8'h04;
    else begin
      case (opc)
        OP_ADD: res_c = RW'(a) + RW'(b);
        OP_SUB: res_c = {{(OPW-1){sub_c[OPW]}}, sub_c};
        OP_MUL: res_c = RW'(a) * RW'(b);
        OP_DIV: begin
          if (b == '0) status_c = 8'h02;
          else         res_c    = {div_quo, div_rem};
        end
        default: status_c = 8'h01;
      endcase
    end
  end

`ifdef FRAME_CHECKSUM_EN
  always_comb begin
    res_ck_c = status_c;
    for (int i = 0; i < int'(2 * NB); i++) res_ck_c = res_ck_c ^ res_c[i*8 +: 8];
  end
`endif

  always_comb begin
    rsp_byte_c = RSP_EOF;
    if (idx == 4'd0)                 rsp_byte_c = RSP_SOF;
    else if (idx == 4'd1)            rsp_byte_c = status;
    else if (idx <= 4'(2 * NB + 1))  rsp_byte_c = rsp_sr[RW-1 -: 8];
`ifdef FRAME_CHECKSUM_EN
    else if (idx == 4'(2 * NB + 2))  rsp_byte_c = rsp_ck;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_data   <= '0;
      tx_start  <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      tx_start  <= issue_c;
      frame_err <= err_c;
      if (issue_c) tx_data <= rsp_byte_c;
      if (eof_ok_c)    busy <= 1'b1;
      else if (done_c) busy <= 1'b0;
      if (done_c) frame_cnt <= frame_cnt + 16'd1;
      if (busy && rx_valid && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      opc      <= '0;
      a        <= '0;
      b        <= '0;
      bcnt     <= '0;
      idle_cnt <= '0;
      div_rem  <= '0;
      div_quo  <= '0;
      div_cnt  <= '0;
      status   <= '0;
      rsp_sr   <= '0;
      idx      <= '0;
      ck_ok    <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
      rx_ck    <= '0;
      rsp_ck   <= '0;
`endif
    end else begin
      idle_cnt <= (in_frame_c && !rx_valid) ? idle_cnt + 1'b1 : '0;
      case (state_q)
        S_IDLE: if (rx_valid && rx_data == REQ_SOF) begin
          bcnt  <= '0;
          ck_ok <= 1'b1;
`ifdef FRAME_CHECKSUM_EN
          rx_ck <= '0;
`endif
        end
        S_OPC: if (rx_valid) begin
          opc <= rx_data;
`ifdef FRAME_CHECKSUM_EN
          rx_ck <= rx_ck ^ rx_data;
`endif
        end
        S_OPA: if (rx_valid) begin
          a    <= OPW'({a, rx_data});
          bcnt <= last_byte_c ? 3'd0 : bcnt + 3'd1;
`ifdef FRAME_CHECKSUM_EN
          rx_ck <= rx_ck ^ rx_data;
`endif
        end
        S_OPB: if (rx_valid) begin
          b    <= OPW'({b, rx_data});
          bcnt <= last_byte_c ? 3'd0 : bcnt + 3'd1;
`ifdef FRAME_CHECKSUM_EN
          rx_ck <= rx_ck ^ rx_data;
`endif
        end
`ifdef FRAME_CHECKSUM_EN
        S_CHK: if (rx_valid) ck_ok <= (rx_data == rx_ck);
`endif
        S_END: if (eof_ok_c) begin
          div_rem <= '0;
          div_quo <= a;
          div_cnt <= '0;
        end
        S_EXEC: begin
          if (div_busy_c) begin
            div_rem <= div_ge_c ? div_sub_c[OPW-1:0] : div_sh_c[OPW-1:0];
            div_quo <= {div_quo[OPW-2:0], div_ge_c};
            div_cnt <= div_cnt + 1'b1;
          end else begin
            status <= status_c;
            rsp_sr <= res_c;
            idx    <= '0;
`ifdef FRAME_CHECKSUM_EN
            rsp_ck <= res_ck_c;
`endif
          end
        end
        S_RSP: if (idx >= 4'd2 && idx <= 4'(2 * NB + 1)) rsp_sr <= {rsp_sr[RW-9:0], 8'h00};
        S_WAIT: if (tx_done && !last_rsp_c) idx <= idx + 4'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_alu_frame_engine.sv
// Directed bench for uart_alu_frame_engine: an 8-bit and a 16-bit instance, each driven by a small transmitter responder.
// Expected response frames include the checksum byte when FRAME_CHECKSUM_EN is defined.
`timescale 1ns/1ps
module tb_uart_alu_frame_engine;
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data8, rx_data16, tx_data8, tx_data16;
  logic        rx_valid8, rx_valid16, tx_start8, tx_start16, tx_done8, tx_done16;
  logic        busy8, busy16, frame_err8, frame_err16;
  logic [15:0] frame_cnt8, frame_cnt16;
  logic [7:0]  drop_cnt8, drop_cnt16;
  logic [7:0]  cap8[$];
  logic [7:0]  cap16[$];
  int          n_vec = 0, n_err = 0;
  int          exp_fc8 = 0, exp_fc16 = 0;
  int          lat, cnt;

  always #5 clk = ~clk;

  uart_alu_frame_engine #(.OPW(8), .TIMEOUT_CYC(50)) dut8 (
    .clk(clk), .reset(reset), .rx_data(rx_data8), .rx_valid(rx_valid8),
    .tx_data(tx_data8), .tx_start(tx_start8), .tx_done(tx_done8), .busy(busy8),
    .frame_err(frame_err8), .frame_cnt(frame_cnt8), .drop_cnt(drop_cnt8));

  uart_alu_frame_engine #(.OPW(16), .TIMEOUT_CYC(50)) dut16 (
    .clk(clk), .reset(reset), .rx_data(rx_data16), .rx_valid(rx_valid16),
    .tx_data(tx_data16), .tx_start(tx_start16), .tx_done(tx_done16), .busy(busy16),
    .frame_err(frame_err16), .frame_cnt(frame_cnt16), .drop_cnt(drop_cnt16));

  // Transmitter models: capture each started byte, finish it three cycles later
  initial begin : tx8_model
    tx_done8 = 1'b0;
    forever begin
      @(negedge clk);
      tx_done8 = 1'b0;
      if (tx_start8) begin
        cap8.push_back(tx_data8);
        repeat (3) @(negedge clk);
        tx_done8 = 1'b1;
      end
    end
  end

  initial begin : tx16_model
    tx_done16 = 1'b0;
    forever begin
      @(negedge clk);
      tx_done16 = 1'b0;
      if (tx_start16) begin
        cap16.push_back(tx_data16);
        repeat (3) @(negedge clk);
        tx_done16 = 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] val);
    @(negedge clk);
    if (sel) begin rx_data16 = val; rx_valid16 = 1'b1; end
    else     begin rx_data8  = val; rx_valid8  = 1'b1; end
    @(negedge clk);
    rx_valid8  = 1'b0;
    rx_valid16 = 1'b0;
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] opc, input logic [15:0] a,
                            input logic [15:0] b);
`ifdef FRAME_CHECKSUM_EN
    logic [7:0] ck;
`endif
    send_byte(sel, 8'h0C);
    send_byte(sel, opc);
    if (sel) send_byte(sel, a[15:8]);
    send_byte(sel, a[7:0]);
    if (sel) send_byte(sel, b[15:8]);
    send_byte(sel, b[7:0]);
`ifdef FRAME_CHECKSUM_EN
    ck = opc ^ a[7:0] ^ b[7:0] ^ (sel ? (a[15:8] ^ b[15:8]) : 8'h00);
    send_byte(sel, ck);
`endif
    send_byte(sel, 8'hFF);
  endtask

  task automatic measure_latency(input bit sel, output int lcyc);
    lcyc = 0;
    while (!(sel ? tx_start16 : tx_start8) && lcyc < 100) begin
      @(negedge clk);
      lcyc++;
    end
  endtask

  // exp holds the frame without checksum, MSB first; n is its byte count
  task automatic wait_frame(input bit sel, input string tag, input int n, input logic [63:0] exp);
    int         cyc;
    logic [7:0] got[$];
`ifdef FRAME_CHECKSUM_EN
    logic [7:0] ck;
    ck = 8'h00;
    for (int i = 1; i < n - 1; i++) ck = ck ^ exp[8*(n-1-i) +: 8];
    exp = ((exp >> 8) << 16) | (64'(ck) << 8) | 64'(exp[7:0]);
    n = n + 1;
`endif
    cyc = 0;
    while (cyc < 600 && !(((sel ? cap16.size() : cap8.size()) >= n) && !(sel ? busy16 : busy8))) begin
      @(negedge clk);
      cyc++;
    end
    if (sel) begin got = cap16; cap16.delete(); end
    else     begin got = cap8;  cap8.delete();  end
    check({tag, "_busy"}, 32'(sel ? busy16 : busy8), 32'd0);
    check({tag, "_len"}, 32'(got.size()), 32'(n));
    for (int i = 0; i < n && i < got.size(); i++)
      check($sformatf("%s_b%0d", tag, i), 32'(got[i]), 32'(exp[8*(n-1-i) +: 8]));
    if (sel) begin exp_fc16++; check({tag, "_fcnt"}, 32'(frame_cnt16), 32'(exp_fc16)); end
    else     begin exp_fc8++;  check({tag, "_fcnt"}, 32'(frame_cnt8),  32'(exp_fc8));  end
  endtask

  initial begin
    reset = 1'b0;
    rx_data8 = '0; rx_data16 = '0; rx_valid8 = 1'b0; rx_valid16 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_start", 32'(tx_start8), 32'd0);
    check("rst_tx_data",  32'(tx_data8),  32'd0);
    check("rst_busy",     32'(busy8),     32'd0);
    check("rst_frame_err", 32'(frame_err8), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt8), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt8), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // 8-bit operations
    send_frame(1'b0, 8'h01, 16'h05, 16'h03);
    check("add_busy", 32'(busy8), 32'd1);
    measure_latency(1'b0, lat);
    check("add_latency", 32'(lat), 32'd2);
    wait_frame(1'b0, "add8", 5, 64'h20_00_00_08_0A);
    send_frame(1'b0, 8'h02, 16'h03, 16'h05);
    wait_frame(1'b0, "sub8", 5, 64'h20_00_FF_FE_0A);
    send_frame(1'b0, 8'h03, 16'hFF, 16'hFF);
    wait_frame(1'b0, "mul8", 5, 64'h20_00_FE_01_0A);
    send_frame(1'b0, 8'h04, 16'h09, 16'h00);
    measure_latency(1'b0, lat);
    check("div0_latency", 32'(lat), 32'd2);
    wait_frame(1'b0, "div0", 5, 64'h20_02_00_00_0A);
    send_frame(1'b0, 8'h07, 16'h01, 16'h01);
    wait_frame(1'b0, "badop", 5, 64'h20_01_00_00_0A);
    send_frame(1'b0, 8'h04, 16'h64, 16'h07);
    measure_latency(1'b0, lat);
    check("div8_latency", 32'(lat), 32'd10);
    wait_frame(1'b0, "div8", 5, 64'h20_00_0E_02_0A);

`ifdef FRAME_CHECKSUM_EN
    send_byte(1'b0, 8'h0C); send_byte(1'b0, 8'h01); send_byte(1'b0, 8'h05);
    send_byte(1'b0, 8'h03); send_byte(1'b0, 8'h00); send_byte(1'b0, 8'hFF);
    wait_frame(1'b0, "badck", 5, 64'h20_04_00_00_0A);
`endif

    // Bad end byte: error pulse, no response
    send_byte(1'b0, 8'h0C); send_byte(1'b0, 8'h01); send_byte(1'b0, 8'h01); send_byte(1'b0, 8'h01);
`ifdef FRAME_CHECKSUM_EN
    send_byte(1'b0, 8'h01);
`endif
    send_byte(1'b0, 8'h11);
    check("badeof_err", 32'(frame_err8), 32'd1);
    @(negedge clk);
    check("badeof_pulse", 32'(frame_err8), 32'd0);
    repeat (20) @(negedge clk);
    check("badeof_notx", 32'(cap8.size()), 32'd0);
    check("badeof_fcnt", 32'(frame_cnt8), 32'(exp_fc8));

    // Inter-byte timeout after the opcode, then a fresh frame
    send_byte(1'b0, 8'h0C); send_byte(1'b0, 8'h01);
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (frame_err8) cnt++;
    end
    check("timeout_err", 32'(cnt), 32'd1);
    check("timeout_notx", 32'(cap8.size()), 32'd0);
    send_frame(1'b0, 8'h01, 16'h02, 16'h03);
    wait_frame(1'b0, "post_to", 5, 64'h20_00_00_05_0A);

    // Bytes arriving during a response are dropped
    send_frame(1'b0, 8'h01, 16'hFF, 16'hFF);
    send_byte(1'b0, 8'h0C); send_byte(1'b0, 8'h01); send_byte(1'b0, 8'hFF);
    wait_frame(1'b0, "drop", 5, 64'h20_00_01_FE_0A);
    check("drop_cnt", 32'(drop_cnt8), 32'd3);
    repeat (10) @(negedge clk);
    check("drop_notx", 32'(cap8.size()), 32'd0);

    // 16-bit operands
    send_frame(1'b1, 8'h04, 16'h0064, 16'h0007);
    measure_latency(1'b1, lat);
    check("div16_latency", 32'(lat), 32'd18);
    wait_frame(1'b1, "div16", 7, 64'h20_00_00_0E_00_02_0A);
    send_frame(1'b1, 8'h01, 16'hFFFF, 16'h0001);
    wait_frame(1'b1, "add16", 7, 64'h20_00_00_01_00_00_0A);
    send_frame(1'b1, 8'h02, 16'h0005, 16'h0007);
    wait_frame(1'b1, "sub16", 7, 64'h20_00_FF_FF_FF_FE_0A);

    // Reset during the third response byte
    send_frame(1'b0, 8'h01, 16'h05, 16'h03);
    cnt = 0;
    while (cap8.size() < 3 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check("mid_rsp_reached", 32'(cap8.size()), 32'd3);
    #1 reset = 1'b0;
    #1;
    check("arst_tx_start", 32'(tx_start8), 32'd0);
    check("arst_tx_data",  32'(tx_data8),  32'd0);
    check("arst_busy",     32'(busy8),     32'd0);
    check("arst_frame_cnt", 32'(frame_cnt8), 32'd0);
    check("arst_drop_cnt", 32'(drop_cnt8), 32'd0);
    check("arst_frame_cnt16", 32'(frame_cnt16), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    cap8.delete();
    exp_fc8 = 0;
    repeat (40) @(negedge clk);
    check("arst_no_resend", 32'(cap8.size()), 32'd0);
    send_frame(1'b0, 8'h01, 16'h05, 16'h03);
    wait_frame(1'b0, "after_rst", 5, 64'h20_00_00_08_0A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
